instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset; bits [1:0] SHALL be zero.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port imem_req_valid, output, 1 bit: instruction-memory request valid.
REQ-005 The block SHALL have port imem_req_ready, input, 1 bit: memory accepts the request this cycle.
REQ-006 The block SHALL have port imem_req_addr, output, 32 bits: request byte address, always equal to the PC.
REQ-007 The block SHALL have port imem_rsp_valid, input, 1 bit: response data valid.
REQ-008 The block SHALL have port imem_rsp_data, input, 32 bits: fetched instruction word.
REQ-009 The block SHALL have port redirect_valid, input, 1 bit: branch/jump redirect from execute.
REQ-010 The block SHALL have port redirect_pc, input, 32 bits: redirect target; bits [1:0] SHALL be ignored and treated as zero.
REQ-011 The block SHALL have port instr_valid, output, 1 bit: decode-side instruction valid.
REQ-012 The block SHALL have port instr_ready, input, 1 bit: decode accepts the instruction.
REQ-013 The block SHALL have port instr, output, 32 bits: held instruction word.
REQ-014 The block SHALL have port instr_pc, output, 32 bits: PC of the held instruction.
REQ-015 The block SHALL have ports opcode[6:0], funct3[2:0], funct7[6:0], rd[4:0], rs1[4:0] and rs2[4:0], all outputs: fields sliced from instr for the ALU decoder.

Function
REQ-016 The FSM SHALL have exactly four states: REQ, WAIT, FULL and DROP.
REQ-017 Handshake rule: at most one memory request SHALL be outstanding at any time.
REQ-018 REQ state: imem_req_valid=1.
- On imem_req_ready: go to WAIT.
- On redirect_valid with no imem_req_ready: pc<=redirect_pc and stay in REQ.
- On redirect_valid with imem_req_ready in the same cycle: pc<=redirect_pc and go to DROP.
REQ-019 WAIT state: on imem_rsp_valid without redirect: instr<=imem_rsp_data, instr_pc<=pc, pc<=pc+4, go to FULL.
REQ-020 WAIT state with redirect_valid:
- If imem_rsp_valid is also high: discard the response, pc<=redirect_pc, go to REQ.
- Otherwise: pc<=redirect_pc, go to DROP.
REQ-021 FULL state: instr_valid=1 unless redirect_valid is high, in which case instr_valid SHALL be forced to 0 in the same cycle (combinational mask).
REQ-022 FULL state exits:
- On instr_valid && instr_ready: go to REQ.
- On redirect_valid: pc<=redirect_pc, go to REQ; the held instruction is dropped.
REQ-023 DROP state: wait for imem_rsp_valid, discard the data, go to REQ; a redirect in DROP SHALL update pc and remain in DROP.
REQ-024 Outputs outside FULL: imem_req_valid=0 outside REQ; instr_valid=0 outside FULL.
REQ-025 Hold rule: instr, instr_pc and all field outputs SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-026 PC arithmetic SHALL be 32-bit modulo 2^32: pc+4 from 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-027 Field slicing:
- opcode=instr[6:0], rd=instr[11:7], funct3=instr[14:12]
- rs1=instr[19:15], rs2=instr[24:20], funct7=instr[31:25]
REQ-028 Latency: with memory always ready and a 1-cycle response, the first instr_valid SHALL occur 2 cycles after the request cycle, and sustained throughput SHALL be 1 instruction per 3 cycles.
REQ-029 An imem_rsp_valid arriving in REQ or FULL is a protocol violation; the block SHALL ignore it.

Reset
REQ-030 While rst=1, asynchronously and regardless of clk: state=REQ, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC.
REQ-031 On the first clk edge after rst deasserts, imem_req_valid SHALL be 1 with imem_req_addr=RESET_PC.
REQ-032 Reset during WAIT or DROP SHALL abandon the outstanding request; memory is reset by the same rst.

Structure
REQ-033 A shared package fetch_pkg SHALL contain the FSM state enum (REQ, WAIT, FULL, DROP), the NOP_INSTR constant 32'h0000_0013 and the opcode constants (OP=7'h33, OP_IMM=7'h13, LOAD=7'h03, STORE=7'h23, BRANCH=7'h63).
REQ-034 The block SHALL be one module with no sub-modules; the field outputs connect directly to alu_decoder opcode/funct3/funct7.

Verification
REQ-035 Reset: RESET_PC=32'h100, rst pulse -> imem_req_valid=1, addr=32'h100, instr=32'h13, instr_valid=0.
REQ-036 Basic fetch: ready=1, rsp 32'h40B5_0533 one cycle later -> instr_valid=1, instr_pc=32'h100, opcode=7'h33, funct3=0, funct7=7'h20, rd=10, rs1=10, rs2=11; next request addr=32'h104.
REQ-037 Backpressure: instr_ready=0 for 5 cycles in FULL -> instr, instr_pc and fields constant and no new request; then instr_ready=1 -> REQ next cycle.
REQ-038 Redirect in WAIT: redirect_pc=32'h200, response arrives 3 cycles later -> FSM passes through DROP, the response is never presented, and the next request addr=32'h200.
REQ-039 Redirect in REQ with req_ready in the same cycle, redirect_pc=32'h203 -> DROP; after the response, request addr=32'h200.
REQ-040 Wrap: redirect to 32'hFFFF_FFFC, fetch one instruction -> instr_pc=32'hFFFF_FFFC, next request addr=32'h0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, the NOP word and
// the major opcodes used by the fetch and decode stages.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    FULL,
    DROP
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;

endpackage

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch: issues a request at the PC, holds the
// returned word for decode and follows execute-stage redirects.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic [31:0]  redirect_tgt;
  logic         unused_redirect_lsb;

  // Targets are word aligned; the low bits of the redirect are ignored.
  assign redirect_tgt        = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    instr_pc_d     = instr_pc_q;
    imem_req_valid = 1'b0;
    instr_valid    = 1'b0;

    unique case (state_q)
      REQ: begin
        imem_req_valid = 1'b1;
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          // A request accepted alongside a redirect fetches a stale PC.
          if (imem_req_ready) state_d = DROP;
        end else if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = imem_rsp_valid ? REQ : DROP;
        end else if (imem_rsp_valid) begin
          instr_d    = imem_rsp_data;
          instr_pc_d = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = FULL;
        end
      end
      FULL: begin
        instr_valid = ~redirect_valid;
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = REQ;
        end else if (instr_ready) begin
          state_d = REQ;
        end
      end
      DROP: begin
        if (redirect_valid) pc_d = redirect_tgt;
        // Once the stale response is consumed nothing is outstanding.
        if (imem_rsp_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign imem_req_addr = pc_q;
  assign instr         = instr_q;
  assign instr_pc      = instr_pc_q;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign funct7 = instr_q[31:25];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, basic fetch, backpressure, redirects,
// PC wrap and asynchronous reset during an outstanding request.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  int checks = 0;
  int errors = 0;

  instr_fetch #(
    .RESET_PC(32'h0000_0100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .rd            (rd),
    .rs1           (rs1),
    .rs2           (rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;

    // Reset is asynchronous: outputs valid before any clock edge.
    #2;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h1);
    check("rst_addr", imem_req_addr, 32'h100);
    check("rst_instr", instr, 32'h13);
    check("rst_instr_pc", instr_pc, 32'h100);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    step();
    step();
    rst = 1'b0;
    step();
    check("post_rst_req_valid", {31'b0, imem_req_valid}, 32'h1);
    check("post_rst_addr", imem_req_addr, 32'h100);

    // Basic fetch: request accepted, response one cycle later.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("wait_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("wait_instr_valid", {31'b0, instr_valid}, 32'h0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h40B5_0533;
    step();
    imem_rsp_valid = 1'b0;
    check("fetch_valid", {31'b0, instr_valid}, 32'h1);
    check("fetch_instr", instr, 32'h40B5_0533);
    check("fetch_pc", instr_pc, 32'h100);
    check("fetch_opcode", {25'b0, opcode}, 32'h33);
    check("fetch_funct3", {29'b0, funct3}, 32'h0);
    check("fetch_funct7", {25'b0, funct7}, 32'h20);
    check("fetch_rd", {27'b0, rd}, 32'd10);
    check("fetch_rs1", {27'b0, rs1}, 32'd10);
    check("fetch_rs2", {27'b0, rs2}, 32'd11);

    // Backpressure: everything holds and no request goes out.
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", {31'b0, instr_valid}, 32'h1);
      check("bp_instr", instr, 32'h40B5_0533);
      check("bp_pc", instr_pc, 32'h100);
      check("bp_fields", {funct7, rs2, rs1, funct3, rd, opcode}, 32'h40B5_0533);
      check("bp_no_req", {31'b0, imem_req_valid}, 32'h0);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("accept_req_valid", {31'b0, imem_req_valid}, 32'h1);
    check("accept_addr", imem_req_addr, 32'h104);
    check("accept_instr_valid", {31'b0, instr_valid}, 32'h0);

    // Redirect in WAIT, response three cycles after the redirect.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    check("rw_drop_req", {31'b0, imem_req_valid}, 32'h0);
    check("rw_drop_addr", imem_req_addr, 32'h200);
    step();
    check("rw_drop_hold", {31'b0, imem_req_valid | instr_valid}, 32'h0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    check("rw_no_present", {31'b0, instr_valid}, 32'h0);
    check("rw_req_valid", {31'b0, imem_req_valid}, 32'h1);
    check("rw_addr", imem_req_addr, 32'h200);
    check("rw_instr_kept", instr, 32'h40B5_0533);

    // Redirect in REQ with the request accepted in the same cycle.
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    check("rr_drop_req", {31'b0, imem_req_valid}, 32'h0);
    check("rr_drop_addr", imem_req_addr, 32'h200);
    imem_rsp_valid = 1'b1;
    step();
    imem_rsp_valid = 1'b0;
    check("rr_req_valid", {31'b0, imem_req_valid}, 32'h1);
    check("rr_addr", imem_req_addr, 32'h200);

    // Stray response in REQ is ignored.
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    step();
    imem_rsp_valid = 1'b0;
    check("stray_req_valid", {31'b0, imem_req_valid}, 32'h1);
    check("stray_instr", instr, 32'h40B5_0533);

    // Wrap: redirect without acceptance stays in REQ at the new PC.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    check("wrap_req_valid", {31'b0, imem_req_valid}, 32'h1);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h00A0_0093;
    step();
    imem_rsp_valid = 1'b0;
    check("wrap_valid", {31'b0, instr_valid}, 32'h1);
    check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    check("wrap_opcode", {25'b0, opcode}, 32'h13);
    check("wrap_rd", {27'b0, rd}, 32'd1);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("wrap_next_addr", imem_req_addr, 32'h0);

    // Redirect in FULL masks instr_valid combinationally and drops the word.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0063;
    step();
    imem_rsp_valid = 1'b0;
    check("full_pc", instr_pc, 32'h0);
    check("full_valid", {31'b0, instr_valid}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    #1;
    check("mask_valid", {31'b0, instr_valid}, 32'h0);
    step();
    redirect_valid = 1'b0;
    check("full_redir_req", {31'b0, imem_req_valid}, 32'h1);
    check("full_redir_addr", imem_req_addr, 32'h300);
    check("full_redir_valid", {31'b0, instr_valid}, 32'h0);

    // Asynchronous reset while a request is outstanding.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("pre_arst_req", {31'b0, imem_req_valid}, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_req_valid", {31'b0, imem_req_valid}, 32'h1);
    check("arst_addr", imem_req_addr, 32'h100);
    check("arst_instr", instr, 32'h13);
    check("arst_instr_pc", instr_pc, 32'h100);
    step();
    rst = 1'b0;
    step();
    check("arst_after_addr", imem_req_addr, 32'h100);
    check("arst_after_valid", {31'b0, imem_req_valid}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
